// File: rtl/sub_sched_if.sv
// Request/response bundle between the round controller / key scheduler and sub_sched.
// The slave side is the scheduler; the master side is the pair of requesters.
interface sub_sched_if;
  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_in;
  logic         st_done;
  logic [127:0] st_out;
  logic         kw_valid;
  logic         kw_ready;
  logic [31:0]  kw_in;
  logic         kw_done;
  logic [31:0]  kw_out;

  modport slave (
    input  st_valid, st_in, kw_valid, kw_in,
    output st_ready, st_done, st_out, kw_ready, kw_done, kw_out
  );

  modport master (
    output st_valid, st_in, kw_valid, kw_in,
    input  st_ready, st_done, st_out, kw_ready, kw_done, kw_out
  );
endinterface

// File: rtl/sub_sched.sv
// Time-multiplexed SubBytes/SubWord engine sharing one 32-bit S-box lane between two requesters.
// Define SUB_SCHED_KEY_PRIO_EN for fixed key priority on ties; default is round-robin.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] b;
    t = x;
    for (int i = 0; i < 6; i++) begin
      t = gmul(gmul(t, t), x);
    end
    b = gmul(t, t);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = sub_byte(in_byte);
endmodule

module sub_sched (
  input  logic       clk,
  input  logic       rst_n,
  sub_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ST, KW} state_e;

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         st_done_q, st_done_d;
  logic         kw_done_q, kw_done_d;
  logic [31:0]  lane_in, lane_out;
  logic         st_acc, kw_acc, st_wins_tie;

`ifdef SUB_SCHED_KEY_PRIO_EN
  assign st_wins_tie = 1'b0;
`else
  logic last_kw_q, last_kw_d;
  assign st_wins_tie = last_kw_q;
`endif

  // Only IDLE grants; a tie goes to the state requester when the key won last time.
  assign st_acc = (state_q == IDLE) && bus.st_valid && (!bus.kw_valid || st_wins_tie);
  assign kw_acc = (state_q == IDLE) && bus.kw_valid && (!bus.st_valid || !st_wins_tie);

  assign bus.st_ready = st_acc;
  assign bus.kw_ready = kw_acc;
  assign bus.st_done  = st_done_q;
  assign bus.st_out   = st_out_q;
  assign bus.kw_done  = kw_done_q;
  assign bus.kw_out   = kw_out_q;

  always_comb begin
    lane_in = buf_q[31:0];
    if (state_q == ST) begin
      case (beat_q)
        2'd0:    lane_in = buf_q[127:96];
        2'd1:    lane_in = buf_q[95:64];
        2'd2:    lane_in = buf_q[63:32];
        default: lane_in = buf_q[31:0];
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sbox u_sbox (
      .in_byte  (lane_in[8*g +: 8]),
      .out_byte (lane_out[8*g +: 8])
    );
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
`ifndef SUB_SCHED_KEY_PRIO_EN
    last_kw_d = last_kw_q;
    if (st_acc)      last_kw_d = 1'b0;
    else if (kw_acc) last_kw_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (st_acc) begin
          buf_d   = bus.st_in;
          beat_d  = 2'd0;
          state_d = ST;
        end else if (kw_acc) begin
          buf_d   = {96'd0, bus.kw_in};
          state_d = KW;
        end
      end
      ST: begin
        case (beat_q)
          2'd0:    buf_d[127:96] = lane_out;
          2'd1:    buf_d[95:64]  = lane_out;
          2'd2:    buf_d[63:32]  = lane_out;
          default: buf_d[31:0]   = lane_out;
        endcase
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          st_out_d  = buf_d;
          st_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      KW: begin
        kw_out_d  = lane_out;
        kw_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      buf_q     <= 128'd0;
      st_out_q  <= 128'd0;
      kw_out_q  <= 32'd0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
`ifndef SUB_SCHED_KEY_PRIO_EN
      last_kw_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      buf_q     <= buf_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
`ifndef SUB_SCHED_KEY_PRIO_EN
      last_kw_q <= last_kw_d;
`endif
    end
  end
endmodule

// File: tb/tb_sub_sched.sv
// Scoreboard bench for sub_sched: requester tasks push expected results, a negedge monitor checks them.
module tb_sub_sched;
  logic clk = 1'b0;
  logic rst_n;

  sub_sched_if bus();

  sub_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] ST_A     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST_A_EXP = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ST_B     = 128'h102030405060708090a0b0c0d0e0f000;
  localparam logic [127:0] ST_B_EXP = 128'hcab7040953d051cd60e0e7ba70e18c63;
  localparam logic [31:0]  KW_A     = 32'hcf4f3c09;
  localparam logic [31:0]  KW_A_EXP = 32'h8a84eb01;
  localparam logic [31:0]  KW_B     = 32'h01020304;
  localparam logic [31:0]  KW_B_EXP = 32'h7c777bf2;
  localparam logic [31:0]  KW_C     = 32'h00000000;
  localparam logic [31:0]  KW_C_EXP = 32'h63636363;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int last_st_acc = 0;
  int last_kw_acc = 0;
  int rearm_c0;
  logic [127:0] st_exp[$];
  int           st_acc[$];
  logic [31:0]  kw_exp[$];
  int           kw_acc[$];
  int           grant_log[$];
  logic [127:0] prev_st = 128'd0;
  logic [31:0]  prev_kw = 32'd0;
`ifdef SUB_SCHED_KEY_PRIO_EN
  int exp_order[6] = '{1, 1, 1, 0, 0, 0};
`else
  int exp_order[6] = '{0, 1, 0, 1, 0, 1};
`endif

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation and its latency.
  always @(negedge clk) begin
    if (bus.st_done) begin
      if (st_exp.size() == 0) check_output("st_unexpected_done", 128'd1, 128'd0);
      else begin
        check_output("st_out", bus.st_out, st_exp.pop_front());
        check_output("st_latency", 128'(cycle - st_acc.pop_front()), 128'd4);
      end
      prev_st = bus.st_out;
    end else check_output("st_out_stable", bus.st_out, prev_st);
    if (bus.kw_done) begin
      if (kw_exp.size() == 0) check_output("kw_unexpected_done", 128'd1, 128'd0);
      else begin
        check_output("kw_out", 128'(bus.kw_out), 128'(kw_exp.pop_front()));
        check_output("kw_latency", 128'(cycle - kw_acc.pop_front()), 128'd1);
      end
      prev_kw = bus.kw_out;
    end else check_output("kw_out_stable", 128'(bus.kw_out), 128'(prev_kw));
  end

  always @(negedge rst_n) begin
    prev_st = 128'd0;
    prev_kw = 32'd0;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_state(input logic [127:0] d, input logic [127:0] e);
    bus.st_in    = d;
    bus.st_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.st_ready) begin
        st_exp.push_back(e);
        st_acc.push_back(cycle + 1);
        last_st_acc = cycle + 1;
        grant_log.push_back(0);
        @(negedge clk);
        bus.st_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check_output("st_accept_timeout", 128'd1, 128'd0);
    bus.st_valid = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] d, input logic [31:0] e);
    bus.kw_in    = d;
    bus.kw_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.kw_ready) begin
        kw_exp.push_back(e);
        kw_acc.push_back(cycle + 1);
        last_kw_acc = cycle + 1;
        grant_log.push_back(1);
        @(negedge clk);
        bus.kw_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check_output("kw_accept_timeout", 128'd1, 128'd0);
    bus.kw_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #2;
      if (st_exp.size() == 0 && kw_exp.size() == 0) begin
        @(negedge clk);
        return;
      end
    end
    check_output("drain_timeout", 128'd1, 128'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.st_valid = 1'b0;
    bus.kw_valid = 1'b0;
    bus.st_in    = 128'd0;
    bus.kw_in    = 32'd0;

    @(negedge clk);
    check_output("rst_st_out", bus.st_out, 128'd0);
    check_output("rst_kw_out", 128'(bus.kw_out), 128'd0);
    check_output("rst_st_done", 128'(bus.st_done), 128'd0);
    check_output("rst_kw_done", 128'(bus.kw_done), 128'd0);
    check_output("rst_st_ready", 128'(bus.st_ready), 128'd0);
    check_output("rst_kw_ready", 128'(bus.kw_ready), 128'd0);
    rst_n = 1'b1;

    send_state(ST_A, ST_A_EXP);
    wait_drain();
    send_key(KW_A, KW_A_EXP);
    wait_drain();

    send_state(ST_B, ST_B_EXP);
    wait_drain();
    send_key(KW_B, KW_B_EXP);
    send_key(KW_C, KW_C_EXP);
    wait_drain();

    do_reset();
    fork
      send_state(ST_A, ST_A_EXP);
      send_key(KW_A, KW_A_EXP);
    join
`ifdef SUB_SCHED_KEY_PRIO_EN
    check_output("tie_order", 128'(last_st_acc - last_kw_acc), 128'd2);
`else
    check_output("tie_order", 128'(last_kw_acc - last_st_acc), 128'd5);
`endif
    wait_drain();

    grant_log.delete();
    fork
      begin
        send_state(ST_A, ST_A_EXP);
        send_state(ST_B, ST_B_EXP);
        send_state(ST_A, ST_A_EXP);
      end
      begin
        send_key(KW_A, KW_A_EXP);
        send_key(KW_B, KW_B_EXP);
        send_key(KW_C, KW_C_EXP);
      end
    join
    check_output("grant_count", 128'(grant_log.size()), 128'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check_output($sformatf("grant_%0d", i), 128'(grant_log[i]), 128'(exp_order[i]));
    end
    wait_drain();

    fork
      send_state(ST_B, ST_B_EXP);
      begin
        repeat (3) @(negedge clk);
        send_key(KW_B, KW_B_EXP);
      end
    join
    check_output("kw_wait_busy", 128'(last_kw_acc - last_st_acc), 128'd5);
    wait_drain();

    send_state(ST_A, ST_A_EXP);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_st_out", bus.st_out, 128'd0);
    check_output("midrst_kw_out", 128'(bus.kw_out), 128'd0);
    check_output("midrst_st_done", 128'(bus.st_done), 128'd0);
    check_output("midrst_kw_done", 128'(bus.kw_done), 128'd0);
    check_output("midrst_st_ready", 128'(bus.st_ready), 128'd0);
    #1 rst_n = 1'b1;
    st_exp.delete();
    st_acc.delete();
    repeat (6) @(negedge clk);
    rearm_c0 = cycle;
    send_state(ST_B, ST_B_EXP);
    check_output("rearm_accept", 128'(last_st_acc), 128'(rearm_c0 + 1));
    wait_drain();

    check_output("queues_empty", 128'(st_exp.size() + kw_exp.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub_sched.md
# sub_sched

Time-multiplexed SubBytes engine and arbiter. It shares one 32-bit S-box lane (four `sbox` instances) between two requesters:
- the round datapath, which needs a full 128-bit SubBytes processed as four 32-bit beats;
- the key expansion, which needs a single 32-bit SubWord.

It sits between the round controller and key scheduler on one side and the S-box lane on the other, and replaces the 16-instance combinational `subbytes` in area-reduced builds.

## Interface
- No parameters; widths fixed by AES.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `st_valid`  in  1  state request; held with `st_in` until accepted.
- `st_ready`  out  1  state request accepted this cycle when `st_valid & st_ready`.
- `st_in`  in  128  state to substitute; byte 15 at [127:120].
- `st_done`  out  1  one-cycle pulse; `st_out` is the new result.
- `st_out`  out  128  substituted state; held until the next state completion.
- `kw_valid`  in  1  key-word request; held with `kw_in` until accepted.
- `kw_ready`  out  1  key-word request accepted when `kw_valid & kw_ready`.
- `kw_in`  in  32  word to SubWord (already rotated by the requester).
- `kw_done`  out  1  one-cycle pulse; `kw_out` is the new result.
- `kw_out`  out  32  substituted word; held until the next key completion.

## Operation
- FSM states: IDLE, ST (beat counter 0..3), KW.
- Both readys are low outside IDLE. In IDLE, a ready is high only for the arbitration winner among the asserted valids.
- Readys are combinational from the valids and state; valids never depend on readys.
- On state accept: capture `st_in` into a 128-bit work buffer and go to ST with beat = 0.
- Each ST cycle feeds buffer word `beat` through the lane. Beat 0 = [127:96], beat 3 = [31:0].
- The lane result overwrites that word; beat increments.
- At beat 3, load the final buffer into `st_out`, pulse `st_done`, and return to IDLE.
- On key accept: capture `kw_in` into the work register and go to KW.
- In KW: lane result goes to `kw_out`, pulse `kw_done`, return to IDLE.
- Arbitration applies only when both valids are high in IDLE. With a single valid, that requester wins.
- Round-robin pointer `last_kw`: set on key accept, cleared on state accept. Reset value is 1, so the state requester wins the first tie.
- Reset: FSM=IDLE; beat=0; buffers, `st_out` and `kw_out` = 0; `st_done`, `kw_done`, `st_ready`, `kw_ready` = 0; `last_kw` = 1.
- Reset asserted mid-operation aborts the operation with no done pulse. Requesters must re-present.
- The lane operates on registered data only; there is no combinational path from `st_in`/`kw_in` to the outputs.

## Timing
- Accept at edge E0.
  - State: beats complete at E1..E4; `st_done` is high in the cycle after E4. Latency is 4 edges.
  - Key: `kw_done` is high in the cycle after E1. Latency is 1 edge.
- The done cycle is an IDLE cycle, so a new accept is possible in that same cycle.
- Maximum rate: one state op per 5 cycles or one key op per 2 cycles.
- `st_out`/`kw_out` change only on the edge that raises their own done; they are stable otherwise.
- A request arriving while busy waits. Its valid must stay high; no request is ever dropped.

## Configuration
- `SUB_SCHED_KEY_PRIO_EN` defined:
  - the key requester wins every tie (fixed priority);
  - `last_kw` is not implemented.
- Undefined: round-robin as described above.
- A state request is never pre-empted once accepted in either build.

## Test plan
- State only: `st_in`=00112233445566778899aabbccddeeff accepted at E0 → `st_done` after E4, `st_out`=638293c31bfc33f5c4eeacea4bc12816; `kw_done` stays 0.
- Key only: `kw_in`=cf4f3c09 accepted at E0 → `kw_done` after E1, `kw_out`=8a84eb01; `st_out` unchanged.
- Tie from reset, both valid with the vectors above, default build → state accepted first. The key is accepted in the `st_done` cycle, and `kw_done` follows 2 cycles later. With `SUB_SCHED_KEY_PRIO_EN` → key first, state accepted in the `kw_done` cycle.
- Sustained ties, default build → grants alternate state, key, state, key; neither requester is starved.
- Key valid raised during ST beat 2 → `kw_ready` stays 0 until IDLE, and `st_out` is still correct.
- `rst_n` pulsed low during ST beat 1 → all outputs 0 immediately. There is no `st_done` and FSM is IDLE. A re-presented request then completes normally.
